jump_link_ctrl: RTL and testbench

Controller for unconditional jumps in the 5-stage MIPS pipeline. Decodes J/JAL/JR/JALR in ID and stalls ID while a JR/JALR source register is still pending in EX/MEM. It then redirects the PC, flushes IF/ID, and drives the write-back destination select (rd or $31) plus the link value. It sequences the existing write-back destination mux and replaces the ad-hoc jump logic in the ID stage.

---
 rtl/jump_link_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_jump_link_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/jump_link_ctrl.sv
// jump_link_ctrl
// Controller for unconditional jumps (J/JAL/JR/JALR) in the ID stage of a
// 5-stage MIPS pipeline. It waits while a register-jump source is still
// being produced in EX (any write) or MEM (load), then redirects the PC,
// bubbles IF/ID and supplies the link destination/value for write-back.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   id_valid/id_inst  instruction currently in ID
//   id_pc_plus4       PC+4 of the ID instruction (also the link value)
//   rs_data           register-file/forwarded value of inst[25:21]
//   ex_wr_en/ex_wr_reg, mem_wr_en/mem_wr_reg/mem_is_load
//                     destinations still in flight, used for the hazard check
//   ex_flush          older-instruction flush; kills the jump in ID
//   stall             freeze PC and IF/ID (combinational)
//   pc_redirect/pc_target/flush_if
//                     one-cycle redirect pulse with the latched target
//   link_sel/link_reg/link_data
//                     write-back destination select, register and value
//   stall_timeout     sticky flag: hazard stall reached STALL_LIMIT cycles
//   jump_count        number of committed jumps (wraps)
module jump_link_ctrl #(
   parameter int unsigned STALL_LIMIT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [31:0] id_inst,
   input  logic [31:0] id_pc_plus4,
   input  logic [31:0] rs_data,
   input  logic        ex_wr_en,
   input  logic [4:0]  ex_wr_reg,
   input  logic        mem_wr_en,
   input  logic [4:0]  mem_wr_reg,
   input  logic        mem_is_load,
   input  logic        ex_flush,
   output logic        stall,
   output logic        pc_redirect,
   output logic [31:0] pc_target,
   output logic        flush_if,
   output logic        link_sel,
   output logic [4:0]  link_reg,
   output logic [31:0] link_data,
   output logic        stall_timeout,
   output logic [15:0] jump_count
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_RS  = 2'd1,
      REDIRECT = 2'd2
   } state_t;

   localparam logic [3:0] LIMIT_C = 4'(STALL_LIMIT);

   state_t      state_r, state_next_s;
   logic [31:0] pc_target_r;
   logic        link_sel_r;
   logic [4:0]  link_reg_r;
   logic [31:0] link_data_r;
   logic [3:0]  stall_cnt_r, stall_cnt_next_s;
   logic        stall_timeout_r;
   logic [15:0] jump_count_r;

   logic [5:0]  opcode_s, funct_s;
   logic [4:0]  rs_s, rd_s;
   logic        is_j_s, is_jal_s, is_jr_s, is_jalr_s, is_jump_s, is_reg_jump_s;
   logic        hazard_s;
   logic [31:0] target_s;
   logic        link_sel_s;
   logic [4:0]  link_reg_s;
   logic        latch_s, stall_s, count_s, in_redirect_s;

   // Instruction decode, register-jump hazard detection and target/link selection.
   always_comb begin
      opcode_s      = id_inst[31:26];
      funct_s       = id_inst[5:0];
      rs_s          = id_inst[25:21];
      rd_s          = id_inst[15:11];
      is_j_s        = (opcode_s == 6'b000010);
      is_jal_s      = (opcode_s == 6'b000011);
      is_jr_s       = (opcode_s == 6'b000000) && (funct_s == 6'b001000);
      is_jalr_s     = (opcode_s == 6'b000000) && (funct_s == 6'b001001);
      is_reg_jump_s = is_jr_s | is_jalr_s;
      is_jump_s     = is_j_s | is_jal_s | is_reg_jump_s;
      // $0 is never actually written, so it can never be pending
      hazard_s = is_reg_jump_s && (rs_s != 5'd0) &&
                 ((ex_wr_en && (ex_wr_reg == rs_s)) ||
                  (mem_wr_en && mem_is_load && (mem_wr_reg == rs_s)));
      if (is_reg_jump_s) begin
         target_s = rs_data;
      end else begin
         target_s = {id_pc_plus4[31:28], id_inst[25:0], 2'b00};
      end
      if (is_jal_s) begin
         link_sel_s = 1'b1;
         link_reg_s = 5'd31;
      end else if (is_jalr_s) begin
         // JALR to $0 discards the link, so write-back stays on its normal path
         link_sel_s = (rd_s != 5'd0);
         link_reg_s = rd_s;
      end else begin
         link_sel_s = 1'b0;
         link_reg_s = 5'd0;
      end
   end

   // Next-state logic, stall request, latch enable and stall-counter update.
   always_comb begin
      state_next_s     = state_r;
      latch_s          = 1'b0;
      stall_s          = 1'b0;
      count_s          = 1'b0;
      stall_cnt_next_s = stall_cnt_r;
      case (state_r)
         IDLE: begin
            stall_cnt_next_s = 4'd0;
            if (!ex_flush && id_valid && is_jump_s) begin
               if (hazard_s) begin
                  stall_s          = 1'b1;
                  stall_cnt_next_s = 4'd1;
                  state_next_s     = WAIT_RS;
               end else begin
                  latch_s      = 1'b1;
                  state_next_s = REDIRECT;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         WAIT_RS: begin
            if (ex_flush) begin
               stall_cnt_next_s = 4'd0;
               state_next_s     = IDLE;
            end else if (hazard_s) begin
               stall_s = 1'b1;
               if (stall_cnt_r != 4'hF) begin
                  stall_cnt_next_s = stall_cnt_r + 4'd1;
               end else begin
                  stall_cnt_next_s = stall_cnt_r;
               end
            end else begin
               latch_s      = 1'b1;
               state_next_s = REDIRECT;
            end
         end
         REDIRECT: begin
            // ID holds the slot being flushed, so its contents are ignored
            stall_cnt_next_s = 4'd0;
            count_s          = !ex_flush;
            state_next_s     = IDLE;
         end
         default: begin
            stall_cnt_next_s = 4'd0;
            state_next_s     = IDLE;
         end
      endcase
   end

   // State, stall counter and sticky timeout flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r         <= IDLE;
         stall_cnt_r     <= 4'd0;
         stall_timeout_r <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         stall_cnt_r <= stall_cnt_next_s;
         if (stall_s && (stall_cnt_next_s == LIMIT_C)) begin
            stall_timeout_r <= 1'b1;
         end
      end
   end

   // Jump target and link information, latched when the jump is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_target_r  <= 32'd0;
         link_sel_r   <= 1'b0;
         link_reg_r   <= 5'd0;
         link_data_r  <= 32'd0;
         jump_count_r <= 16'd0;
      end else begin
         if (latch_s) begin
            pc_target_r <= target_s;
            link_sel_r  <= link_sel_s;
            link_reg_r  <= link_reg_s;
            link_data_r <= id_pc_plus4;
         end else if (in_redirect_s && ex_flush) begin
            // a flushed jump must not leave a link write behind
            link_sel_r <= 1'b0;
         end
         if (count_s) begin
            jump_count_r <= jump_count_r + 16'd1;
         end
      end
   end

   // The redirect pulse comes straight from the REDIRECT state register; a
   // same-cycle flush from an older instruction cancels it.
   assign in_redirect_s = (state_r == REDIRECT);
   assign pc_redirect   = in_redirect_s & ~ex_flush;
   assign flush_if      = in_redirect_s & ~ex_flush;
   assign link_sel      = link_sel_r & ~(in_redirect_s & ex_flush);
   assign stall         = stall_s & rst_n;
   assign pc_target     = pc_target_r;
   assign link_reg      = link_reg_r;
   assign link_data     = link_data_r;
   assign stall_timeout = stall_timeout_r;
   assign jump_count    = jump_count_r;

endmodule

// File: tb/tb_jump_link_ctrl.sv
// Directed testbench for jump_link_ctrl: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_jump_link_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        id_valid = 1'b0;
   logic [31:0] id_inst = 32'd0;
   logic [31:0] id_pc_plus4 = 32'd0;
   logic [31:0] rs_data = 32'd0;
   logic        ex_wr_en = 1'b0;
   logic [4:0]  ex_wr_reg = 5'd0;
   logic        mem_wr_en = 1'b0;
   logic [4:0]  mem_wr_reg = 5'd0;
   logic        mem_is_load = 1'b0;
   logic        ex_flush = 1'b0;
   logic        stall, pc_redirect, flush_if, link_sel, stall_timeout;
   logic [31:0] pc_target, link_data;
   logic [4:0]  link_reg;
   logic [15:0] jump_count;

   int errors = 0;
   int checks = 0;

   jump_link_ctrl #(.STALL_LIMIT(15)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_inst(id_inst),
      .id_pc_plus4(id_pc_plus4), .rs_data(rs_data), .ex_wr_en(ex_wr_en),
      .ex_wr_reg(ex_wr_reg), .mem_wr_en(mem_wr_en), .mem_wr_reg(mem_wr_reg),
      .mem_is_load(mem_is_load), .ex_flush(ex_flush), .stall(stall),
      .pc_redirect(pc_redirect), .pc_target(pc_target), .flush_if(flush_if),
      .link_sel(link_sel), .link_reg(link_reg), .link_data(link_data),
      .stall_timeout(stall_timeout), .jump_count(jump_count)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      id_valid = 1'b0; id_inst = 32'd0; id_pc_plus4 = 32'd0; rs_data = 32'd0;
      ex_wr_en = 1'b0; ex_wr_reg = 5'd0; mem_wr_en = 1'b0; mem_wr_reg = 5'd0;
      mem_is_load = 1'b0; ex_flush = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] inst, input logic [31:0] pc4, input logic [31:0] rsd);
      id_valid = 1'b1; id_inst = inst; id_pc_plus4 = pc4; rs_data = rsd;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      // a hazarded JR during reset must not raise stall
      drive(32'h01000008, 32'h00400004, 32'h0); ex_wr_en = 1'b1; ex_wr_reg = 5'd8;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", stall); end
      checks++; if (pc_redirect !== 1'b0 || flush_if !== 1'b0) begin errors++; $display("FAIL reset_redirect got=%0b/%0b exp=0/0", pc_redirect, flush_if); end
      checks++; if (pc_target !== 32'd0 || link_data !== 32'd0) begin errors++; $display("FAIL reset_regs target=%h link_data=%h exp=0", pc_target, link_data); end
      checks++; if (link_sel !== 1'b0 || link_reg !== 5'd0) begin errors++; $display("FAIL reset_link sel=%0b reg=%0d exp=0/0", link_sel, link_reg); end
      checks++; if (stall_timeout !== 1'b0 || jump_count !== 16'd0) begin errors++; $display("FAIL reset_counts to=%0b cnt=%0d exp=0/0", stall_timeout, jump_count); end
      clear_inputs();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_jal();
      drive(32'h0C000040, 32'h00400008, 32'h0);
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL jal_nostall got=%0b exp=0", stall); end
      tick(); clear_inputs(); #1;
      checks++; if (pc_redirect !== 1'b1 || flush_if !== 1'b1) begin errors++; $display("FAIL jal_redirect got=%0b/%0b exp=1/1", pc_redirect, flush_if); end
      checks++; if (pc_target !== 32'h00000100) begin errors++; $display("FAIL jal_target got=%h exp=00000100", pc_target); end
      checks++; if (link_sel !== 1'b1 || link_reg !== 5'd31 || link_data !== 32'h00400008) begin errors++; $display("FAIL jal_link sel=%0b reg=%0d data=%h exp=1/31/00400008", link_sel, link_reg, link_data); end
      tick();
      checks++; if (pc_redirect !== 1'b0 || jump_count !== 16'd1) begin errors++; $display("FAIL jal_after redirect=%0b cnt=%0d exp=0/1", pc_redirect, jump_count); end
      checks++; if (link_sel !== 1'b1) begin errors++; $display("FAIL jal_link_hold got=%0b exp=1", link_sel); end
   endtask

   task automatic test_jr_hazard();
      drive(32'h01000008, 32'h00400010, 32'hDEADBEEC); ex_wr_en = 1'b1; ex_wr_reg = 5'd8;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL jr_stall1 got=%0b exp=1", stall); end
      tick();
      checks++; if (stall !== 1'b1 || pc_redirect !== 1'b0) begin errors++; $display("FAIL jr_stall2 stall=%0b redirect=%0b exp=1/0", stall, pc_redirect); end
      tick();
      ex_wr_en = 1'b0; rs_data = 32'h00400200; #1;
      checks++; if (stall !== 1'b0 || pc_redirect !== 1'b0) begin errors++; $display("FAIL jr_release stall=%0b redirect=%0b exp=0/0", stall, pc_redirect); end
      tick(); clear_inputs(); #1;
      checks++; if (pc_redirect !== 1'b1 || pc_target !== 32'h00400200 || link_sel !== 1'b0) begin errors++; $display("FAIL jr_redirect r=%0b t=%h sel=%0b exp=1/00400200/0", pc_redirect, pc_target, link_sel); end
      tick();
      checks++; if (jump_count !== 16'd2) begin errors++; $display("FAIL jr_count got=%0d exp=2", jump_count); end
   endtask

   task automatic test_jalr();
      // a non-load MEM write to rs does not stall
      drive(32'h01202809, 32'h00400010, 32'h00401000); mem_wr_en = 1'b1; mem_wr_reg = 5'd9; mem_is_load = 1'b0;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL jalr_nonload got=%0b exp=0", stall); end
      mem_is_load = 1'b1; #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL jalr_load_stall got=%0b exp=1", stall); end
      tick();
      mem_wr_en = 1'b0; mem_is_load = 1'b0; #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL jalr_release got=%0b exp=0", stall); end
      tick(); clear_inputs(); #1;
      checks++; if (pc_redirect !== 1'b1 || pc_target !== 32'h00401000) begin errors++; $display("FAIL jalr_redirect r=%0b t=%h exp=1/00401000", pc_redirect, pc_target); end
      checks++; if (link_sel !== 1'b1 || link_reg !== 5'd5 || link_data !== 32'h00400010) begin errors++; $display("FAIL jalr_link sel=%0b reg=%0d data=%h exp=1/5/00400010", link_sel, link_reg, link_data); end
      tick();
      // rd = 0 variant
      drive(32'h01200009, 32'h00400020, 32'h00402000); mem_wr_en = 1'b1; mem_wr_reg = 5'd9; mem_is_load = 1'b1;
      tick();
      mem_wr_en = 1'b0; mem_is_load = 1'b0;
      tick(); clear_inputs(); #1;
      checks++; if (pc_redirect !== 1'b1 || pc_target !== 32'h00402000 || link_sel !== 1'b0) begin errors++; $display("FAIL jalr_rd0 r=%0b t=%h sel=%0b exp=1/00402000/0", pc_redirect, pc_target, link_sel); end
      tick();
      checks++; if (jump_count !== 16'd4) begin errors++; $display("FAIL jalr_count got=%0d exp=4", jump_count); end
   endtask

   task automatic test_jr_zero();
      drive(32'h00000008, 32'h00400030, 32'h12345678); ex_wr_en = 1'b1; ex_wr_reg = 5'd0;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL jr0_nostall got=%0b exp=0", stall); end
      tick(); clear_inputs(); #1;
      checks++; if (pc_redirect !== 1'b1 || pc_target !== 32'h12345678) begin errors++; $display("FAIL jr0_redirect r=%0b t=%h exp=1/12345678", pc_redirect, pc_target); end
      tick();
   endtask

   task automatic test_j_region();
      drive(32'h08000010, 32'hA0000004, 32'h0);
      tick(); clear_inputs(); #1;
      checks++; if (pc_redirect !== 1'b1 || pc_target !== 32'hA0000040 || link_sel !== 1'b0) begin errors++; $display("FAIL j_region r=%0b t=%h sel=%0b exp=1/A0000040/0", pc_redirect, pc_target, link_sel); end
      tick();
      checks++; if (jump_count !== 16'd6) begin errors++; $display("FAIL j_count got=%0d exp=6", jump_count); end
   endtask

   task automatic test_back_to_back();
      drive(32'h0C000040, 32'h00400008, 32'h0);
      tick();
      drive(32'h08000010, 32'hA0000004, 32'h0); #1;
      checks++; if (pc_redirect !== 1'b1 || pc_target !== 32'h00000100) begin errors++; $display("FAIL b2b_first r=%0b t=%h exp=1/00000100", pc_redirect, pc_target); end
      tick();
      checks++; if (pc_redirect !== 1'b0 || pc_target !== 32'h00000100 || jump_count !== 16'd7) begin errors++; $display("FAIL b2b_ignore r=%0b t=%h cnt=%0d exp=0/00000100/7", pc_redirect, pc_target, jump_count); end
      tick(); clear_inputs(); #1;
      checks++; if (pc_redirect !== 1'b1 || pc_target !== 32'hA0000040) begin errors++; $display("FAIL b2b_second r=%0b t=%h exp=1/A0000040", pc_redirect, pc_target); end
      tick();
   endtask

   task automatic test_flush_wait();
      drive(32'h01000008, 32'h00400040, 32'h0); ex_wr_en = 1'b1; ex_wr_reg = 5'd8;
      tick();
      ex_flush = 1'b1; #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flushw_stall got=%0b exp=0", stall); end
      tick(); clear_inputs(); #1;
      checks++; if (pc_redirect !== 1'b0) begin errors++; $display("FAIL flushw_redirect got=%0b exp=0", pc_redirect); end
      tick();
      checks++; if (pc_redirect !== 1'b0 || jump_count !== 16'd8) begin errors++; $display("FAIL flushw_count r=%0b cnt=%0d exp=0/8", pc_redirect, jump_count); end
   endtask

   task automatic test_flush_redirect();
      drive(32'h0C000080, 32'h00400050, 32'h0);
      tick(); clear_inputs(); ex_flush = 1'b1; #1;
      checks++; if (pc_redirect !== 1'b0 || flush_if !== 1'b0 || link_sel !== 1'b0) begin errors++; $display("FAIL flushr_outs r=%0b f=%0b sel=%0b exp=0/0/0", pc_redirect, flush_if, link_sel); end
      tick(); ex_flush = 1'b0; #1;
      checks++; if (jump_count !== 16'd8 || link_sel !== 1'b0) begin errors++; $display("FAIL flushr_after cnt=%0d sel=%0b exp=8/0", jump_count, link_sel); end
   endtask

   task automatic test_reset_in_redirect();
      drive(32'h0C000040, 32'h00400008, 32'h0);
      tick(); clear_inputs(); #1;
      checks++; if (pc_redirect !== 1'b1) begin errors++; $display("FAIL rstr_pre got=%0b exp=1", pc_redirect); end
      rst_n = 1'b0; #1;
      checks++; if (pc_redirect !== 1'b0 || flush_if !== 1'b0 || link_sel !== 1'b0) begin errors++; $display("FAIL rstr_pulse r=%0b f=%0b sel=%0b exp=0/0/0", pc_redirect, flush_if, link_sel); end
      checks++; if (pc_target !== 32'd0 || link_reg !== 5'd0 || link_data !== 32'd0 || jump_count !== 16'd0) begin errors++; $display("FAIL rstr_regs t=%h reg=%0d data=%h cnt=%0d exp=0", pc_target, link_reg, link_data, jump_count); end
      #2; rst_n = 1'b1;
      tick();
   endtask

   task automatic test_timeout();
      drive(32'h01000008, 32'h00400060, 32'h0); ex_wr_en = 1'b1; ex_wr_reg = 5'd8;
      for (int i = 0; i < 14; i++) tick();
      checks++; if (stall !== 1'b1 || stall_timeout !== 1'b0) begin errors++; $display("FAIL to_14 stall=%0b to=%0b exp=1/0", stall, stall_timeout); end
      tick();
      checks++; if (stall_timeout !== 1'b1) begin errors++; $display("FAIL to_15 got=%0b exp=1", stall_timeout); end
      for (int i = 0; i < 3; i++) tick();
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL to_sat_stall got=%0b exp=1", stall); end
      ex_wr_en = 1'b0; rs_data = 32'h00400300;
      tick(); clear_inputs(); #1;
      checks++; if (pc_redirect !== 1'b1 || pc_target !== 32'h00400300 || stall_timeout !== 1'b1) begin errors++; $display("FAIL to_redirect r=%0b t=%h to=%0b exp=1/00400300/1", pc_redirect, pc_target, stall_timeout); end
      tick();
      checks++; if (stall_timeout !== 1'b1 || jump_count !== 16'd1) begin errors++; $display("FAIL to_sticky to=%0b cnt=%0d exp=1/1", stall_timeout, jump_count); end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_jal();
      test_jr_hazard();
      test_jalr();
      test_jr_zero();
      test_j_region();
      test_back_to_back();
      test_flush_wait();
      test_flush_redirect();
      test_reset_in_redirect();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
